// File: rtl/ext_arbiter_if.sv
// ext_arbiter_if: requester, extension-unit and status signals of ext_arbiter.
// slave  - the arbiter's view.
// master - the environment's view (both requesters plus the extension unit).
interface ext_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_start;
    logic             req1_start;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req0_func3;
    logic [2:0]       req1_func3;
    logic [WIDTH-1:0] req0_r;
    logic [WIDTH-1:0] req1_r;
    logic             req0_done;
    logic             req1_done;
    logic             req0_err;
    logic             req1_err;
    logic             ext_start;
    logic [WIDTH-1:0] ext_a;
    logic [WIDTH-1:0] ext_b;
    logic [2:0]       ext_func3;
    logic [WIDTH-1:0] ext_r;
    logic             ext_done;
    logic             busy;
    logic             owner;

    modport slave (
        input  req0_start, req1_start, req0_a, req0_b, req1_a, req1_b,
               req0_func3, req1_func3, ext_r, ext_done,
        output req0_r, req1_r, req0_done, req1_done, req0_err, req1_err,
               ext_start, ext_a, ext_b, ext_func3, busy, owner
    );

    modport master (
        output req0_start, req1_start, req0_a, req0_b, req1_a, req1_b,
               req0_func3, req1_func3, ext_r, ext_done,
        input  req0_r, req1_r, req0_done, req1_done, req0_err, req1_err,
               ext_start, ext_a, ext_b, ext_func3, busy, owner
    );
endinterface

// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin arbiter sharing one extension unit between two
// requesters. Operands are latched at grant and held on ext_a/b/func3 until
// the next grant; each requester's result is held until it is overwritten.
// Build option: define EXT_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles
// (owner gets r=0 with done and err); without it WAIT is unbounded.
//
// state | meaning
// IDLE  | no transaction; grant an eligible requester
// ISSUE | ext_start pulse to the unit
// WAIT  | waiting for ext_done (or timeout)
// RESP  | done (and err) pulse to the owner
module ext_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    ext_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_q;
    logic             last_q;
    logic             hold_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       func3_q;
    logic [WIDTH-1:0] r0_q, r1_q;

    logic             elig0, elig1, grant, grant_idx;
    logic             timeout, capture, err_flag;
    logic [WIDTH-1:0] r_next;

    // The requester served last is not eligible in the IDLE cycle right after
    // its RESP; owner_q still names it then, since it only changes on grant.
    assign elig0     = bus.req0_start && !(hold_q && !owner_q);
    assign elig1     = bus.req1_start && !(hold_q && owner_q);
    assign grant     = (state_q == S_IDLE) && (elig0 || elig1);
    assign grant_idx = (elig0 && elig1) ? ~last_q : elig1;

    assign capture   = (state_q == S_WAIT) && (bus.ext_done || timeout);
    assign r_next    = bus.ext_done ? bus.ext_r : '0;

`ifdef EXT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Timeout fires on the TIMEOUT-th WAIT cycle; a real ext_done that cycle wins
    assign timeout  = (state_q == S_WAIT) && !bus.ext_done &&
                      (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign err_flag = err_q;

    // Count WAIT cycles from 0; remember whether WAIT ended by timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            err_q      <= timeout;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    // No timeout hardware: the compare is constant false, WAIT is unbounded
    assign timeout  = (TIMEOUT < 0);
    assign err_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        bus.ext_start = (state_q == S_ISSUE);
        bus.busy      = (state_q != S_IDLE);
        bus.req0_done = (state_q == S_RESP) && !owner_q;
        bus.req1_done = (state_q == S_RESP) && owner_q;
        bus.req0_err  = (state_q == S_RESP) && !owner_q && err_flag;
        bus.req1_err  = (state_q == S_RESP) && owner_q && err_flag;
    end

    // Grant bookkeeping: owner, round-robin pointer, post-RESP window, operand latches
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            func3_q <= '0;
        end else begin
            hold_q <= (state_q == S_RESP);
            if (grant) begin
                owner_q <= grant_idx;
                last_q  <= grant_idx;
                a_q     <= grant_idx ? bus.req1_a     : bus.req0_a;
                b_q     <= grant_idx ? bus.req1_b     : bus.req0_b;
                func3_q <= grant_idx ? bus.req1_func3 : bus.req0_func3;
            end
        end
    end

    // Result registers: only the owner's is written, when WAIT ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            r0_q <= '0;
            r1_q <= '0;
        end else if (capture) begin
            if (owner_q) r1_q <= r_next;
            else         r0_q <= r_next;
        end
    end

    assign bus.ext_a     = a_q;
    assign bus.ext_b     = b_q;
    assign bus.ext_func3 = func3_q;
    assign bus.req0_r    = r0_q;
    assign bus.req1_r    = r1_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter; the bench also plays the unit.
module tb_ext_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ext_arbiter_if #(.WIDTH(WIDTH)) bus ();
    ext_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // extension unit model
    bit               u_pend = 1'b0;
    int               u_cnt = 0;
    int               u_k_fixed = 1;
    bit               u_k_rand = 1'b0;
    int               u_last_k = 1;
    logic [WIDTH-1:0] u_a, u_b;
    logic [2:0]       u_f;

    function automatic logic [WIDTH-1:0] unit_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [2:0] f);
        case (f)
            3'd0:    return a * b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a ^ b;
            3'd4:    return a | b;
            3'd5:    return a & b;
            3'd6:    return a << b[4:0];
            default: return ~a;
        endcase
    endfunction

    // Advance to the next negedge and let the unit react (k=0 means never done)
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.ext_done = 1'b0;
        if (u_pend) begin
            u_cnt--;
            if (u_cnt == 0) begin
                bus.ext_done = 1'b1;
                bus.ext_r    = unit_fn(u_a, u_b, u_f);
                u_pend       = 1'b0;
            end
        end
        if (bus.ext_start) begin
            u_last_k = u_k_rand ? int'($urandom_range(1, 5)) : u_k_fixed;
            u_a      = bus.ext_a;
            u_b      = bus.ext_b;
            u_f      = bus.ext_func3;
            u_cnt    = u_last_k;
            u_pend   = (u_last_k > 0);
        end
    endtask

    task automatic apply_reset(input bit kill_unit);
        bus.req0_start = 1'b0;
        bus.req1_start = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        if (kill_unit) u_pend = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b exp 0", bus.owner); end
        checks++; if (bus.ext_start !== 1'b0) begin errors++; $display("FAIL reset_ext_start got %b exp 0", bus.ext_start); end
        checks++;
        if ({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_done_err got %b exp 0000", {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err});
        end
        checks++;
        if (bus.req0_r !== '0 || bus.req1_r !== '0) begin
            errors++; $display("FAIL reset_results got %h %h exp 0 0", bus.req0_r, bus.req1_r);
        end
        checks++;
        if (bus.ext_a !== '0 || bus.ext_b !== '0 || bus.ext_func3 !== 3'd0) begin
            errors++; $display("FAIL reset_latches got %h %h %h exp 0", bus.ext_a, bus.ext_b, bus.ext_func3);
        end
    endtask

    task automatic test_single();
        int t0, ts, td;
        bit other_done;
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 3;
        bus.req0_a = 7; bus.req0_b = 6; bus.req0_func3 = 3'd0; bus.req0_start = 1'b1;
        t0 = cyc; ts = -1; td = -1; other_done = 1'b0;
        for (int i = 0; i < 20 && td < 0; i++) begin
            tick();
            if (bus.ext_start && ts < 0) ts = cyc - t0;
            if (bus.req1_done) other_done = 1'b1;
            if (bus.req0_done) td = cyc - t0;
        end
        checks++; if (ts != 1) begin errors++; $display("FAIL single_start_latency got %0d exp 1", ts); end
        checks++; if (td != 5) begin errors++; $display("FAIL single_done_cycle got %0d exp 5", td); end
        checks++; if (bus.req0_r !== 32'd42) begin errors++; $display("FAIL single_result got %0d exp 42", bus.req0_r); end
        checks++; if (other_done) begin errors++; $display("FAIL single_req1_done got 1 exp 0"); end
        bus.req0_start = 1'b0;
    endtask

    task automatic test_simultaneous();
        int owners[$];
        bit got0, got1;
        logic [WIDTH-1:0] r0, r1;
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 2;
        bus.req0_a = 3; bus.req0_b = 5; bus.req0_func3 = 3'd1;
        bus.req1_a = 9; bus.req1_b = 4; bus.req1_func3 = 3'd2;
        bus.req0_start = 1'b1; bus.req1_start = 1'b1;
        got0 = 1'b0; got1 = 1'b0; r0 = '0; r1 = '0;
        for (int i = 0; i < 40 && !(got0 && got1); i++) begin
            tick();
            if (bus.ext_start) owners.push_back(int'(bus.owner));
            if (bus.req0_done) begin got0 = 1'b1; r0 = bus.req0_r; bus.req0_start = 1'b0; end
            if (bus.req1_done) begin got1 = 1'b1; r1 = bus.req1_r; bus.req1_start = 1'b0; end
        end
        checks++; if (owners.size() != 2) begin errors++; $display("FAIL simul_grants got %0d exp 2", owners.size()); end
        if (owners.size() == 2) begin
            checks++; if (owners[0] != 0) begin errors++; $display("FAIL simul_first_owner got %0d exp 0", owners[0]); end
            checks++; if (owners[1] != 1) begin errors++; $display("FAIL simul_second_owner got %0d exp 1", owners[1]); end
        end
        checks++; if (r0 !== 32'd8) begin errors++; $display("FAIL simul_r0 got %0d exp 8", r0); end
        checks++; if (r1 !== 32'd5) begin errors++; $display("FAIL simul_r1 got %0d exp 5", r1); end
    endtask

    task automatic test_back_to_back();
        int owners[$];
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 1;
        bus.req0_a = 1; bus.req0_b = 2; bus.req0_func3 = 3'd1;
        bus.req1_a = 3; bus.req1_b = 4; bus.req1_func3 = 3'd1;
        bus.req0_start = 1'b1; bus.req1_start = 1'b1;
        for (int i = 0; i < 60 && owners.size() < 4; i++) begin
            tick();
            if (bus.ext_start) owners.push_back(int'(bus.owner));
        end
        checks++; if (owners.size() != 4) begin errors++; $display("FAIL b2b_grants got %0d exp 4", owners.size()); end
        for (int i = 0; i < owners.size() && i < 4; i++) begin
            checks++;
            if (owners[i] != i % 2) begin errors++; $display("FAIL b2b_owner_%0d got %0d exp %0d", i, owners[i], i % 2); end
        end
        bus.req0_start = 1'b0; bus.req1_start = 1'b0;
    endtask

    task automatic test_operand_change();
        bit started, done1, moved;
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 4;
        bus.req1_a = 100; bus.req1_b = 3; bus.req1_func3 = 3'd0; bus.req1_start = 1'b1;
        started = 1'b0; done1 = 1'b0; moved = 1'b0;
        for (int i = 0; i < 20 && !done1; i++) begin
            tick();
            if (bus.ext_start) started = 1'b1;
            if (started && (bus.ext_a !== 32'd100 || bus.ext_b !== 32'd3 || bus.ext_func3 !== 3'd0)) moved = 1'b1;
            if (bus.req1_done) begin
                done1 = 1'b1;
                checks++;
                if (bus.req1_r !== 32'd300) begin errors++; $display("FAIL opchg_result got %0d exp 300", bus.req1_r); end
                bus.req1_start = 1'b0;
            end else if (started) begin
                bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_func3 = 3'($urandom_range(0, 7));
            end
        end
        checks++; if (!done1) begin errors++; $display("FAIL opchg_done got 0 exp 1"); end
        checks++; if (moved) begin errors++; $display("FAIL opchg_ext_operands got changed exp stable 100/3/0"); end
    endtask

    task automatic test_reset_mid();
        bit seen, bad_done, bad_busy, bad_out, late;
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 4;
        bus.req0_a = 2; bus.req0_b = 2; bus.req0_func3 = 3'd0; bus.req0_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            if (bus.ext_start) seen = 1'b1;
        end
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_wait got busy %b exp 1", bus.busy); end
        rst = 1'b0; bus.req0_start = 1'b0;
        tick();
        rst = 1'b1;
        bad_done = 1'b0; bad_busy = 1'b0; bad_out = 1'b0; late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ext_done) late = 1'b1;
            if (bus.req0_done || bus.req1_done) bad_done = 1'b1;
            if (bus.busy || bus.ext_start) bad_busy = 1'b1;
            if (bus.req0_r !== '0 || bus.ext_a !== '0 || bus.ext_b !== '0 || bus.owner !== 1'b0) bad_out = 1'b1;
        end
        checks++; if (!late) begin errors++; $display("FAIL rstmid_late_done got 0 exp 1"); end
        checks++; if (bad_done) begin errors++; $display("FAIL rstmid_done_pulse got 1 exp 0"); end
        checks++; if (bad_busy) begin errors++; $display("FAIL rstmid_busy got 1 exp 0"); end
        checks++; if (bad_out) begin errors++; $display("FAIL rstmid_outputs got nonzero exp reset values"); end
    endtask

    task automatic test_timeout();
        int t0, td;
        bit done0, e0, any_err;
        logic [WIDTH-1:0] r0;
        apply_reset(1'b1);
        u_k_rand = 1'b0; u_k_fixed = 2;
        bus.req0_a = 7; bus.req0_b = 6; bus.req0_func3 = 3'd0; bus.req0_start = 1'b1;
        done0 = 1'b0; any_err = 1'b0;
        for (int i = 0; i < 20 && !done0; i++) begin
            tick();
            if (bus.req0_err) any_err = 1'b1;
            if (bus.req0_done) done0 = 1'b1;
        end
        bus.req0_start = 1'b0;
        checks++; if (!done0 || any_err) begin errors++; $display("FAIL tmo_normal got done %b err %b exp 1 0", done0, any_err); end
        tick(); tick();
        u_k_fixed = 0;
        bus.req0_a = 1; bus.req0_b = 1; bus.req0_start = 1'b1;
        t0 = cyc; td = -1; e0 = 1'b0; r0 = 'x; any_err = 1'b0;
        for (int i = 0; i < 40 && td < 0; i++) begin
            tick();
            if (bus.req0_err || bus.req1_err) any_err = 1'b1;
            if (bus.req0_done) begin td = cyc - t0; e0 = bus.req0_err; r0 = bus.req0_r; end
        end
`ifdef EXT_TIMEOUT_EN
        checks++; if (td != TIMEOUT + 2) begin errors++; $display("FAIL tmo_done_cycle got %0d exp %0d", td, TIMEOUT + 2); end
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", e0); end
        checks++; if (r0 !== '0) begin errors++; $display("FAIL tmo_result got %h exp 0", r0); end
`else
        checks++; if (td >= 0) begin errors++; $display("FAIL notmo_done got cycle %0d exp none", td); end
        checks++; if (any_err) begin errors++; $display("FAIL notmo_err got 1 exp 0"); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL notmo_busy got %b exp 1", bus.busy); end
`endif
        bus.req0_start = 1'b0;
    endtask

    task automatic test_random();
        bit               m_busy, m_owner, m_last;
        int               m_free_from, m_done_cyc, m_exp_done, n_txn;
        logic [WIDTH-1:0] m_r [2];
        logic [WIDTH-1:0] g_a, g_b;
        logic [2:0]       g_f;
        bit               e0, e1, idle_prev, exp_start, winner, exp_d0, exp_d1, fin;
        bit               s_start [2];
        logic [WIDTH-1:0] s_a [2];
        logic [WIDTH-1:0] s_b [2];
        logic [2:0]       s_f [2];
        apply_reset(1'b1);
        u_k_rand = 1'b1;
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_free_from = cyc; m_done_cyc = -10; m_exp_done = 0; n_txn = 0;
        m_r[0] = '0; m_r[1] = '0; g_a = '0; g_b = '0; g_f = '0;
        for (int i = 0; i < 2; i++) begin s_start[i] = 1'b0; s_a[i] = '0; s_b[i] = '0; s_f[i] = '0; end
        for (int c = 0; c < 3000; c++) begin
            tick();
            // arbitration in the previous cycle, judged from the requests it saw
            idle_prev = !m_busy && (cyc - 1 >= m_free_from);
            e0 = bus.req0_start && !(m_done_cyc == cyc - 2 && !m_owner);
            e1 = bus.req1_start && !(m_done_cyc == cyc - 2 && m_owner);
            exp_start = idle_prev && (e0 || e1);
            winner = (e0 && e1) ? !m_last : e1;
            checks++;
            if (bus.ext_start !== exp_start) begin
                errors++; $display("FAIL rand_ext_start cyc %0d got %b exp %b", cyc, bus.ext_start, exp_start);
            end
            if (exp_start) begin
                m_busy = 1'b1; m_owner = winner; m_last = winner; n_txn++;
                g_a = winner ? bus.req1_a : bus.req0_a;
                g_b = winner ? bus.req1_b : bus.req0_b;
                g_f = winner ? bus.req1_func3 : bus.req0_func3;
                m_exp_done = cyc + 1 + u_last_k;
                checks++;
                if (bus.owner !== winner) begin errors++; $display("FAIL rand_owner cyc %0d got %b exp %b", cyc, bus.owner, winner); end
            end
            if (m_busy) begin
                checks++;
                if ({bus.ext_a, bus.ext_b, bus.ext_func3} !== {g_a, g_b, g_f}) begin
                    errors++;
                    $display("FAIL rand_ext_operands cyc %0d got %h %h %0d exp %h %h %0d",
                             cyc, bus.ext_a, bus.ext_b, bus.ext_func3, g_a, g_b, g_f);
                end
            end
            checks++;
            if (bus.busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, bus.busy, m_busy); end
            exp_d0 = m_busy && cyc == m_exp_done && !m_owner;
            exp_d1 = m_busy && cyc == m_exp_done && m_owner;
            checks++;
            if ({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err} !== {exp_d0, exp_d1, 2'b00}) begin
                errors++;
                $display("FAIL rand_done_err cyc %0d got %b exp %b", cyc,
                         {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}, {exp_d0, exp_d1, 2'b00});
            end
            if (exp_d0 || exp_d1) begin
                m_r[m_owner] = unit_fn(g_a, g_b, g_f);
                m_busy = 1'b0; m_free_from = cyc + 1; m_done_cyc = cyc;
            end
            checks++;
            if (bus.req0_r !== m_r[0] || bus.req1_r !== m_r[1]) begin
                errors++;
                $display("FAIL rand_results cyc %0d got %h %h exp %h %h", cyc, bus.req0_r, bus.req1_r, m_r[0], m_r[1]);
            end
            // requesters: hold until done, then drop or re-request; owner may scribble operands
            for (int i = 0; i < 2; i++) begin
                fin = (i == 0) ? exp_d0 : exp_d1;
                if (s_start[i]) begin
                    if (fin) begin
                        if ($urandom_range(0, 1) == 0) s_start[i] = 1'b0;
                        else begin s_a[i] = $urandom; s_b[i] = $urandom; s_f[i] = 3'($urandom_range(0, 7)); end
                    end else if (m_busy && int'(m_owner) == i && $urandom_range(0, 2) == 0) begin
                        s_a[i] = $urandom; s_b[i] = $urandom; s_f[i] = 3'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    s_start[i] = 1'b1; s_a[i] = $urandom; s_b[i] = $urandom; s_f[i] = 3'($urandom_range(0, 7));
                end
            end
            bus.req0_start = s_start[0]; bus.req0_a = s_a[0]; bus.req0_b = s_b[0]; bus.req0_func3 = s_f[0];
            bus.req1_start = s_start[1]; bus.req1_a = s_a[1]; bus.req1_b = s_b[1]; bus.req1_func3 = s_f[1];
            // stray completions outside WAIT must not disturb anything
            if (!m_busy && !u_pend && $urandom_range(0, 7) == 0) begin
                bus.ext_done = 1'b1; bus.ext_r = $urandom;
            end
        end
        checks++; if (n_txn < 50) begin errors++; $display("FAIL rand_txn_count got %0d exp >=50", n_txn); end
        bus.req0_start = 1'b0; bus.req1_start = 1'b0;
    endtask

    initial begin
        bus.req0_start = 1'b0; bus.req1_start = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_func3 = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_func3 = '0;
        bus.ext_r = '0; bus.ext_done = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_operand_change();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64, max WAIT cycles before abort (used only with EXT_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req0_start, req1_start  input  1 each  level request; held high until that requester's done pulse.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 req0_func3, req1_func3  input  3 each  operation select.
REQ-008 req0_r, req1_r  output  WIDTH each  result, held until that requester's next grant.
REQ-009 req0_done, req1_done  output  1 each  one-cycle completion pulse.
REQ-010 req0_err, req1_err  output  1 each  one-cycle timeout pulse, coincident with done.
REQ-011 ext_start  output  1  one-cycle start pulse to shared extension unit.
REQ-012 ext_a, ext_b, ext_func3  output  WIDTH, WIDTH, 3  latched operands/op to the unit.
REQ-013 ext_r, ext_done  input  WIDTH, 1  unit result and completion pulse.
REQ-014 busy, owner  output  1, 1  transaction in progress; index of granted requester.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-016 IDLE: any eligible start high -> grant, latch that requester's a/b/func3, set owner, go ISSUE.
REQ-017 Both requesting in IDLE -> SHALL grant requester not served last (round-robin pointer); pointer updates on each grant.
REQ-018 ISSUE: ext_start=1 exactly one cycle, ext_a/b/func3 driven from latches and stable ISSUE through RESP; go WAIT.
REQ-019 WAIT: on ext_done=1 capture ext_r into owner's result register, go RESP; ext_done outside WAIT ignored.
REQ-020 RESP: owner's done=1 one cycle, other requester's done/r unchanged; go IDLE.
REQ-021 Served requester's start SHALL be ignored in the IDLE cycle immediately following its RESP (deassert window).
REQ-022 Latency: start seen in IDLE cycle 0 -> ext_start cycle 1; ext_done at cycle 1+k (k>=1) -> done at cycle 2+k.
REQ-023 busy=1 in ISSUE, WAIT, RESP; 0 in IDLE.
REQ-024 Start changes of non-owner during a transaction SHALL not affect latched operands or owner.
REQ-025 Operand changes of owner after grant SHALL be ignored.

Reset
REQ-026 rst=0 at a rising edge -> IDLE, busy=0, owner=0, pointer favours req0, ext_start=0, all done/err=0, req0_r=req1_r=0, latches=0.
REQ-027 Reset mid-transaction SHALL abandon it with no done pulse; late ext_done after reset ignored.

Configuration
REQ-028 Macro EXT_TIMEOUT_EN defined: WAIT counter counts from 0; TIMEOUT cycles without ext_done -> owner's r=0, go RESP with done=1 and err=1.
REQ-029 EXT_TIMEOUT_EN undefined: no counter, WAIT indefinite, req0_err/req1_err tied 0.

Verification
REQ-030 req0 a=7 b=6 func3=0, unit done after 3 cycles -> ext_start 1 cycle after request, req0_done cycle 5, req0_r=42, req1_done=0.
REQ-031 req0,req1 start same IDLE cycle after reset -> req0 granted first (owner=0), then req1 (owner=1), both results correct.
REQ-032 Both held continuously for 4 transactions -> owner sequence 0,1,0,1.
REQ-033 req1 operands changed during WAIT of req1 -> ext_a/ext_b unchanged, req1_r from original operands.
REQ-034 rst low during WAIT, then ext_done -> FSM IDLE, no done pulse, outputs at reset values.
REQ-035 With EXT_TIMEOUT_EN, TIMEOUT=8, unit never done -> req0_done=req0_err=1 same cycle, req0_r=0; without macro busy stays 1.
